tft_timing_gen: RTL and testbench

TFT_TIMING_GEN -- requirements
Module: tft_timing_gen

---
 rtl/tft_timing_gen.sv | 149 ++++++++++++++
 tb/tb_tft_timing_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tft_timing_gen.sv
// Raster timing generator for a parallel-RGB TFT panel: sync, data-enable,
// line/frame strobes and a pixel request that leads data-enable by LEAD_X clocks.
module tft_timing_gen #(
    parameter int   H_PIXEL_LENGTH = 800,
    parameter int   H_FRONT_PORCH  = 210,
    parameter int   H_SYNC_LENGTH  = 1,
    parameter int   H_BACK_PORCH   = 45,
    parameter int   V_PIXEL_LENGTH = 480,
    parameter int   V_FRONT_PORCH  = 22,
    parameter int   V_SYNC_LENGTH  = 3,
    parameter int   V_BACK_PORCH   = 20,
    parameter int   LEAD_X         = 2,
    parameter logic HSYNC_POL      = 1'b0,
    parameter logic VSYNC_POL      = 1'b0,
    parameter int   CNT_WIDTH      = 11,
    parameter int   FRAME_WIDTH    = 8
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_run,
    output logic                   out_clk,
    output logic                   out_en,
    output logic                   out_hsync,
    output logic                   out_vsync,
    output logic                   out_line_start,
    output logic                   out_frame_start,
    output logic                   out_pix_req,
    output logic [CNT_WIDTH-1:0]   out_pixelx,
    output logic [CNT_WIDTH-1:0]   out_pixely,
    output logic [FRAME_WIDTH-1:0] out_frame
);

    localparam int H_TOTAL = H_SYNC_LENGTH + H_BACK_PORCH + H_PIXEL_LENGTH + H_FRONT_PORCH;
    localparam int H_START = H_SYNC_LENGTH + H_BACK_PORCH;
    localparam int V_TOTAL = V_SYNC_LENGTH + V_BACK_PORCH + V_PIXEL_LENGTH + V_FRONT_PORCH;
    localparam int V_START = V_SYNC_LENGTH + V_BACK_PORCH;

    // Inclusive upper bounds keep every constant representable in CNT_WIDTH bits.
    localparam logic [CNT_WIDTH-1:0] H_LAST_C      = CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] H_SYNC_C      = CNT_WIDTH'(H_SYNC_LENGTH);
    localparam logic [CNT_WIDTH-1:0] H_ACT_FIRST_C = CNT_WIDTH'(H_START);
    localparam logic [CNT_WIDTH-1:0] H_ACT_LAST_C  = CNT_WIDTH'(H_START + H_PIXEL_LENGTH - 1);
    localparam logic [CNT_WIDTH-1:0] H_REQ_FIRST_C = CNT_WIDTH'(H_START - LEAD_X);
    localparam logic [CNT_WIDTH-1:0] H_REQ_LAST_C  = CNT_WIDTH'(H_START + H_PIXEL_LENGTH - LEAD_X - 1);
    localparam logic [CNT_WIDTH-1:0] V_LAST_C      = CNT_WIDTH'(V_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] V_SYNC_C      = CNT_WIDTH'(V_SYNC_LENGTH);
    localparam logic [CNT_WIDTH-1:0] V_ACT_FIRST_C = CNT_WIDTH'(V_START);
    localparam logic [CNT_WIDTH-1:0] V_ACT_LAST_C  = CNT_WIDTH'(V_START + V_PIXEL_LENGTH - 1);

    generate
        if (H_TOTAL > (1 << CNT_WIDTH)) begin : g_bad_h_total
            $error("tft_timing_gen: H_TOTAL does not fit in CNT_WIDTH");
        end
        if (V_TOTAL > (1 << CNT_WIDTH)) begin : g_bad_v_total
            $error("tft_timing_gen: V_TOTAL does not fit in CNT_WIDTH");
        end
        if ((LEAD_X < 0) || (LEAD_X > H_START)) begin : g_bad_lead
            $error("tft_timing_gen: LEAD_X must be within 0..H_SYNC_LENGTH+H_BACK_PORCH");
        end
    endgenerate

    logic [CNT_WIDTH-1:0]   r_hcnt;
    logic [CNT_WIDTH-1:0]   r_vcnt;
    logic                   r_en;
    logic                   r_hsync;
    logic                   r_vsync;
    logic                   r_line_start;
    logic                   r_frame_start;
    logic                   r_pix_req;
    logic [CNT_WIDTH-1:0]   r_pixelx;
    logic [CNT_WIDTH-1:0]   r_pixely;
    logic [FRAME_WIDTH-1:0] r_frame;

    logic w_h_last;
    logic w_v_last;
    logic w_h_active;
    logic w_v_active;
    logic w_h_req;
    logic w_req;
    logic w_line_start;
    logic w_frame_start;

    assign w_h_last      = (r_hcnt == H_LAST_C);
    assign w_v_last      = (r_vcnt == V_LAST_C);
    assign w_h_active    = (r_hcnt >= H_ACT_FIRST_C) && (r_hcnt <= H_ACT_LAST_C);
    assign w_v_active    = (r_vcnt >= V_ACT_FIRST_C) && (r_vcnt <= V_ACT_LAST_C);
    assign w_h_req       = (r_hcnt >= H_REQ_FIRST_C) && (r_hcnt <= H_REQ_LAST_C);
    assign w_req         = w_h_req && w_v_active;
    assign w_line_start  = (r_hcnt == '0);
    assign w_frame_start = w_line_start && (r_vcnt == '0);

    // Every output is a registered decode of the counter state, so outputs lag the counters by one clock.
    // NOTE: state registers use non-blocking assignments so all of them sample the same pre-edge counter values.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_en          <= 1'b0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_pix_req     <= 1'b0;
            r_pixelx      <= '0;
            r_pixely      <= '0;
            r_frame       <= '0;
        end else if (!in_run) begin
            // Stopped: park the raster at its origin, keep the frame count.
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_en          <= 1'b0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_pix_req     <= 1'b0;
            r_pixelx      <= '0;
            r_pixely      <= '0;
        end else begin
            r_hcnt <= w_h_last ? '0 : r_hcnt + CNT_WIDTH'(1);
            if (w_h_last) begin
                r_vcnt <= w_v_last ? '0 : r_vcnt + CNT_WIDTH'(1);
            end
            r_hsync       <= (r_hcnt < H_SYNC_C) ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= (r_vcnt < V_SYNC_C) ? VSYNC_POL : ~VSYNC_POL;
            r_en          <= w_h_active && w_v_active;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
            r_pix_req     <= w_req;
            r_pixelx      <= w_req ? r_hcnt - H_REQ_FIRST_C : '0;
            r_pixely      <= w_req ? r_vcnt - V_ACT_FIRST_C : '0;
            if (w_frame_start) begin
                r_frame <= r_frame + FRAME_WIDTH'(1);
            end
        end
    end

    assign out_clk         = in_clk;
    assign out_en          = r_en;
    assign out_hsync       = r_hsync;
    assign out_vsync       = r_vsync;
    assign out_line_start  = r_line_start;
    assign out_frame_start = r_frame_start;
    assign out_pix_req     = r_pix_req;
    assign out_pixelx      = r_pixelx;
    assign out_pixely      = r_pixely;
    assign out_frame       = r_frame;

endmodule

// File: tb/tb_tft_timing_gen.sv
// Bench for tft_timing_gen: a raster-position model checked every cycle on three
// builds (LEAD_X=2, LEAD_X=0, FRAME_WIDTH=2), plus hand-computed directed checks.
module tb_tft_timing_gen;

    localparam int H_PIX = 8, H_FP = 2, H_SYNC = 1, H_BP = 3;
    localparam int V_PIX = 4, V_FP = 1, V_SYNC = 1, V_BP = 2;
    localparam int H_TOTAL = H_SYNC + H_BP + H_PIX + H_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_PIX + V_FP;
    localparam int V_START = V_SYNC + V_BP;
    localparam int FRAME_CLKS = H_TOTAL * V_TOTAL;
    localparam int CW = 11;

    logic clk = 1'b0;
    logic rst;
    logic run;

    logic          d0_clk, d0_en, d0_hs, d0_vs, d0_ls, d0_fs, d0_req;
    logic [CW-1:0] d0_x, d0_y;
    logic [7:0]    d0_frame;
    logic          d1_clk, d1_en, d1_hs, d1_vs, d1_ls, d1_fs, d1_req;
    logic [CW-1:0] d1_x, d1_y;
    logic [7:0]    d1_frame;
    logic          d2_clk, d2_en, d2_hs, d2_vs, d2_ls, d2_fs, d2_req;
    logic [CW-1:0] d2_x, d2_y;
    logic [1:0]    d2_frame;

    tft_timing_gen #(
        .H_PIXEL_LENGTH(H_PIX), .H_FRONT_PORCH(H_FP), .H_SYNC_LENGTH(H_SYNC), .H_BACK_PORCH(H_BP),
        .V_PIXEL_LENGTH(V_PIX), .V_FRONT_PORCH(V_FP), .V_SYNC_LENGTH(V_SYNC), .V_BACK_PORCH(V_BP),
        .LEAD_X(2), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_WIDTH(CW), .FRAME_WIDTH(8)
    ) dut0 (
        .in_clk(clk), .in_rst(rst), .in_run(run), .out_clk(d0_clk), .out_en(d0_en),
        .out_hsync(d0_hs), .out_vsync(d0_vs), .out_line_start(d0_ls), .out_frame_start(d0_fs),
        .out_pix_req(d0_req), .out_pixelx(d0_x), .out_pixely(d0_y), .out_frame(d0_frame)
    );

    tft_timing_gen #(
        .H_PIXEL_LENGTH(H_PIX), .H_FRONT_PORCH(H_FP), .H_SYNC_LENGTH(H_SYNC), .H_BACK_PORCH(H_BP),
        .V_PIXEL_LENGTH(V_PIX), .V_FRONT_PORCH(V_FP), .V_SYNC_LENGTH(V_SYNC), .V_BACK_PORCH(V_BP),
        .LEAD_X(0), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_WIDTH(CW), .FRAME_WIDTH(8)
    ) dut1 (
        .in_clk(clk), .in_rst(rst), .in_run(run), .out_clk(d1_clk), .out_en(d1_en),
        .out_hsync(d1_hs), .out_vsync(d1_vs), .out_line_start(d1_ls), .out_frame_start(d1_fs),
        .out_pix_req(d1_req), .out_pixelx(d1_x), .out_pixely(d1_y), .out_frame(d1_frame)
    );

    tft_timing_gen #(
        .H_PIXEL_LENGTH(H_PIX), .H_FRONT_PORCH(H_FP), .H_SYNC_LENGTH(H_SYNC), .H_BACK_PORCH(H_BP),
        .V_PIXEL_LENGTH(V_PIX), .V_FRONT_PORCH(V_FP), .V_SYNC_LENGTH(V_SYNC), .V_BACK_PORCH(V_BP),
        .LEAD_X(2), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_WIDTH(CW), .FRAME_WIDTH(2)
    ) dut2 (
        .in_clk(clk), .in_rst(rst), .in_run(run), .out_clk(d2_clk), .out_en(d2_en),
        .out_hsync(d2_hs), .out_vsync(d2_vs), .out_line_start(d2_ls), .out_frame_start(d2_fs),
        .out_pix_req(d2_req), .out_pixelx(d2_x), .out_pixely(d2_y), .out_frame(d2_frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Raster model: a linear position within the frame plus a count of frames begun.
    int m_pos = 0;
    int m_out_pos = 0;
    int m_frames = 0;
    bit m_active = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos    <= 0;
            m_frames <= 0;
            m_active <= 1'b0;
        end else if (!run) begin
            m_pos    <= 0;
            m_active <= 1'b0;
        end else begin
            m_out_pos <= m_pos;
            m_active  <= 1'b1;
            if (m_pos == 0) m_frames <= m_frames + 1;
            m_pos <= (m_pos + 1) % FRAME_CLKS;
        end
    end

    // Pixel column h+lead is on screen in an active row -> its coordinate is requested now.
    function automatic bit req_at(input int h, input int v, input int lead);
        return (v >= V_START) && (v < V_START + V_PIX) &&
               (h + lead >= H_START) && (h + lead < H_START + H_PIX);
    endfunction

    int c_h, c_v;
    bit c_en, c_r2, c_r0;

    always @(negedge clk) begin
        if (cmp_on) begin
            c_h  = m_out_pos % H_TOTAL;
            c_v  = m_out_pos / H_TOTAL;
            c_en = m_active && req_at(c_h, c_v, 0);
            c_r2 = m_active && req_at(c_h, c_v, 2);
            c_r0 = c_en;
            check("out_clk", d0_clk, clk);
            check("en", d0_en, c_en);
            check("hsync", d0_hs, (m_active && c_h < H_SYNC) ? 0 : 1);
            check("vsync", d0_vs, (m_active && c_v < V_SYNC) ? 0 : 1);
            check("line_start", d0_ls, m_active && c_h == 0);
            check("frame_start", d0_fs, m_active && m_out_pos == 0);
            check("pix_req", d0_req, c_r2);
            check("pixelx", d0_x, c_r2 ? c_h + 2 - H_START : 0);
            check("pixely", d0_y, c_r2 ? c_v - V_START : 0);
            check("frame", d0_frame, m_frames % 256);
            check("lead0_req", d1_req, c_r0);
            check("lead0_pixelx", d1_x, c_r0 ? c_h - H_START : 0);
            check("lead0_en", d1_en, c_en);
            check("fw2_frame", d2_frame, m_frames % 4);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    int hs_low = 0, vs_low = 0, en_cnt = 0, ls_cnt = 0, fs_cnt = 0;
    bit want;

    initial begin
        rst = 1'b1;
        run = 1'b1;
        repeat (2) @(posedge clk);
        #2 cmp_on = 1'b1;
        @(negedge clk);
        check("rst_en", d0_en, 0);
        check("rst_hsync", d0_hs, 1);
        check("rst_vsync", d0_vs, 1);
        check("rst_frame", d0_frame, 0);
        check("rst_pix_req", d0_req, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);

        // Output cycle i reflects raster position i of the running frames.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i < 2 * FRAME_CLKS) begin
                if (!d0_hs) hs_low++;
                if (!d0_vs) vs_low++;
                if (d0_en) en_cnt++;
                if (d0_ls) ls_cnt++;
                if (d0_fs) fs_cnt++;
            end
            if (i == 0 || i == 112 || i == 224) begin
                check("fs_literal", d0_fs, 1);
                check("frame_literal", d0_frame, i / 112 + 1);
                check("fw2_literal", d2_frame, i / 112 + 1);
            end
            if (i >= 42 && i <= 53) begin
                want = (i >= 44 && i <= 51);
                check("row3_req", d0_req, want);
                check("row3_pixelx", d0_x, want ? i - 44 : 0);
                check("row3_pixely", d0_y, 0);
                check("row3_en", d0_en, (i >= 46 && i <= 53));
                check("row3_lead0_req", d1_req, (i >= 46 && i <= 53));
            end
        end
        check("hsync_low_count", hs_low, 16);
        check("vsync_low_count", vs_low, 28);
        check("en_count", en_cnt, 64);
        check("line_start_count", ls_cnt, 16);
        check("frame_start_count", fs_cnt, 2);

        // Next edge would process vcnt=5, hcnt=6: stop for three clocks.
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_en", d0_en, 0);
            check("idle_req", d0_req, 0);
            check("idle_hsync", d0_hs, 1);
            check("idle_frame", d0_frame, 3);
            check("idle_fw2", d2_frame, 3);
        end
        run = 1'b1;
        @(negedge clk);
        check("resume_fs", d0_fs, 1);
        check("resume_ls", d0_ls, 1);
        check("resume_frame", d0_frame, 4);
        check("resume_fw2", d2_frame, 0);

        for (int j = 1; j <= 160; j++) begin
            @(negedge clk);
            if (j == 112) begin
                check("next_fs", d0_fs, 1);
                check("next_frame", d0_frame, 5);
                check("next_fw2", d2_frame, 1);
            end
        end
        check("mid_en", d0_en, 1);
        check("mid_pixelx", d0_x, 4);

        // Asynchronous reset between edges must act immediately.
        #2 rst = 1'b1;
        #1;
        check("async_en", d0_en, 0);
        check("async_req", d0_req, 0);
        check("async_pixelx", d0_x, 0);
        check("async_pixely", d0_y, 0);
        check("async_frame", d0_frame, 0);
        check("async_hsync", d0_hs, 1);
        check("async_vsync", d0_vs, 1);

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("restart_fs", d0_fs, 1);
        check("restart_ls", d0_ls, 1);
        check("restart_frame", d0_frame, 1);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
